// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C slave.
//   ctrl_state_t : transaction controller states
//   I2C_GC_ADDR  : 7-bit general-call address
//   I2C_BYTE_W   : bits per I2C byte
package i2c_pkg;

  localparam int         I2C_BYTE_W  = 8;
  localparam logic [6:0] I2C_GC_ADDR = 7'h00;

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    ADDR_ACK,
    RX_BYTE,
    RX_ACK,
    TX_BYTE,
    TX_MACK,
    WAIT_STOP
  } ctrl_state_t;

endpackage

// File: rtl/i2c_addr_match.sv
// Combinational address compare for the I2C slave.
// Build option: I2C_GENERAL_CALL_EN -- when defined, address byte 0x00 is
// also accepted as a write-only general call (0x01 is still rejected).
// Ports:
//   addr_byte in  8 : received address byte {addr[6:0], r/w}
//   hit       out 1 : this slave is addressed
//   rw        out 1 : R/W bit to latch (1 = read); forced 0 for general call
module i2c_addr_match
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic [I2C_BYTE_W-1:0] addr_byte,
  output logic                  hit,
  output logic                  rw
);

  always_comb begin
    hit = 1'b0;
    rw  = addr_byte[0];
    if (addr_byte[7:1] == SLAVE_ADDR) begin
      hit = 1'b1;
    end
`ifdef I2C_GENERAL_CALL_EN
    else if (addr_byte == {I2C_GC_ADDR, 1'b0}) begin
      hit = 1'b1;
      rw  = 1'b0;
    end
`else
`endif
  end

endmodule

// File: rtl/i2c_slave_ctrl.sv
// Transaction controller for the I2C slave. Consumes SCL edge pulses and
// START/STOP detections, sequences the external SIPO / RX register / PISO,
// matches the slave address and drives ACK and read data on open-drain SDA.
// Build option: I2C_GENERAL_CALL_EN (see i2c_addr_match).
// Ports:
//   clock, reset            : system clock, async active-high reset
//   scl_rise, scl_fall      : one-cycle SCL edge pulses
//   i2c_start, i2c_stop     : START/repeated START and STOP pulses
//   sda_in                  : synchronized SDA level
//   sipo_full, sipo_out     : SIPO status / contents
//   piso_out, piso_empty    : PISO MSB / empty flag
//   tx_ready                : downstream has a transmit byte available
//   sipo_load, sipo_clear   : shift SIPO / clear SIPO
//   store                   : latch sipo_out into RX register
//   piso_load, piso_spit    : load PISO / shift PISO
//   sda_drive_low           : registered open-drain SDA pull-down
//   writeOK                 : RX register holds a new byte (pulse)
//   rd_req                  : a transmit byte was consumed (pulse)
//   rw_bit                  : R/W bit of current transaction (1 = read)
//   busy                    : addressed transaction in progress
module i2c_slave_ctrl
  import i2c_pkg::*;
#(
  parameter logic [6:0] SLAVE_ADDR = 7'h42
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  scl_rise,
  input  logic                  scl_fall,
  input  logic                  i2c_start,
  input  logic                  i2c_stop,
  input  logic                  sda_in,
  input  logic                  sipo_full,
  input  logic [I2C_BYTE_W-1:0] sipo_out,
  input  logic                  piso_out,
  input  logic                  piso_empty,
  input  logic                  tx_ready,
  output logic                  sipo_load,
  output logic                  sipo_clear,
  output logic                  store,
  output logic                  piso_load,
  output logic                  piso_spit,
  output logic                  sda_drive_low,
  output logic                  writeOK,
  output logic                  rd_req,
  output logic                  rw_bit,
  output logic                  busy
);

  ctrl_state_t state, state_nxt;

  logic byte_done;
  logic addr_hit, addr_rw;
  logic sda_nxt, rw_nxt, mack_nxt;
  logic tx_ok;     // tx_ready sampled when the current byte was loaded
  logic bit_pend;  // PISO moved last cycle; its new MSB is now valid
  logic mack;      // master ACKed the byte just sent

  assign byte_done = scl_fall & sipo_full;

  i2c_addr_match #(
    .SLAVE_ADDR(SLAVE_ADDR)
  ) u_addr_match (
    .addr_byte(sipo_out),
    .hit      (addr_hit),
    .rw       (addr_rw)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (i2c_start) begin
      state_nxt = ADDR;
    end else if (i2c_stop) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:      state_nxt = IDLE;
        ADDR:      if (byte_done) state_nxt = addr_hit ? ADDR_ACK : WAIT_STOP;
        ADDR_ACK:  if (scl_fall) state_nxt = rw_bit ? TX_BYTE : RX_BYTE;
        RX_BYTE:   if (byte_done) state_nxt = RX_ACK;
        RX_ACK:    if (scl_fall) state_nxt = RX_BYTE;
        // PISO empties right after the 8th shift; SCL is low at that point
        TX_BYTE:   if (piso_empty) state_nxt = TX_MACK;
        TX_MACK: begin
          if (scl_rise && sda_in)      state_nxt = WAIT_STOP;
          else if (scl_fall && mack)   state_nxt = TX_BYTE;
        end
        WAIT_STOP: state_nxt = WAIT_STOP;
        default:   state_nxt = IDLE;
      endcase
    end
  end

  always_comb begin
    sipo_load  = 1'b0;
    sipo_clear = 1'b0;
    store      = 1'b0;
    piso_load  = 1'b0;
    piso_spit  = 1'b0;
    rd_req     = 1'b0;
    sda_nxt    = sda_drive_low;
    rw_nxt     = rw_bit;
    mack_nxt   = 1'b0;
    if (i2c_start) begin
      sipo_clear = 1'b1;
      sda_nxt    = 1'b0;
      rw_nxt     = 1'b0;
    end else if (i2c_stop) begin
      sda_nxt = 1'b0;
      rw_nxt  = 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          sda_nxt = 1'b0;
          rw_nxt  = 1'b0;
        end
        ADDR: begin
          sipo_load = scl_rise;
          if (byte_done && addr_hit) begin
            sda_nxt = 1'b1;
            rw_nxt  = addr_rw;
          end
        end
        ADDR_ACK: begin
          if (scl_fall) begin
            if (rw_bit) begin
              // SDA keeps the ACK until the loaded MSB becomes visible
              piso_load = 1'b1;
              rd_req    = 1'b1;
            end else begin
              sda_nxt    = 1'b0;
              sipo_clear = 1'b1;
            end
          end
        end
        RX_BYTE: begin
          sipo_load = scl_rise;
          if (byte_done) begin
            store   = 1'b1;
            sda_nxt = 1'b1;
          end
        end
        RX_ACK: begin
          if (scl_fall) begin
            sda_nxt    = 1'b0;
            sipo_clear = 1'b1;
          end
        end
        TX_BYTE: begin
          if (piso_empty) begin
            sda_nxt = 1'b0;
          end else begin
            piso_spit = scl_fall;
            // an underrun byte leaves SDA released so the master reads 0xFF
            if (bit_pend) sda_nxt = tx_ok & ~piso_out;
          end
        end
        TX_MACK: begin
          mack_nxt = mack | (scl_rise & ~sda_in);
          if (scl_fall && mack) begin
            piso_load = 1'b1;
            rd_req    = 1'b1;
          end
        end
        WAIT_STOP: sda_nxt = 1'b0;
        default:   sda_nxt = 1'b0;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      sda_drive_low <= 1'b0;
      rw_bit        <= 1'b0;
      writeOK       <= 1'b0;
      tx_ok         <= 1'b0;
      bit_pend      <= 1'b0;
      mack          <= 1'b0;
    end else begin
      sda_drive_low <= sda_nxt;
      rw_bit        <= rw_nxt;
      writeOK       <= store;
      bit_pend      <= piso_load | piso_spit;
      mack          <= mack_nxt & (state_nxt == TX_MACK);
      if (piso_load) tx_ok <= tx_ready;
    end
  end

  assign busy = (state == ADDR_ACK) || (state == RX_BYTE) || (state == RX_ACK) ||
                (state == TX_BYTE)  || (state == TX_MACK);

endmodule

// File: tb/tb_i2c_slave_ctrl.sv
// Bench for i2c_slave_ctrl: behavioural I2C master plus SIPO, PISO and RX
// register models around the controller; expected write bytes are queued
// when driven and compared when writeOK fires.
`timescale 1ns/1ps
module tb_i2c_slave_ctrl;

  logic       clock = 1'b0;
  logic       reset;
  logic       scl_rise, scl_fall, i2c_start, i2c_stop, sda_in, sipo_full;
  logic [7:0] sipo_out;
  logic       piso_out, piso_empty, tx_ready;
  logic       sipo_load, sipo_clear, store, piso_load, piso_spit;
  logic       sda_drive_low, writeOK, rd_req, rw_bit, busy;

  logic       sda_m, scl_lvl;
  logic [7:0] tx_data, rx_reg, sreg, preg;
  logic [3:0] scnt, pcnt;
  int n_vec = 0, n_err = 0;
  int n_store = 0, n_wok = 0, n_rdreq = 0, n_sda_hi = 0;
  logic [7:0] wq[$];

  always #5 clock = ~clock;

  assign sda_in     = sda_m & ~sda_drive_low;
  assign sipo_full  = (scnt == 4'd8);
  assign sipo_out   = sreg;
  assign piso_out   = preg[7];
  assign piso_empty = (pcnt == 4'd0);

  i2c_slave_ctrl #(.SLAVE_ADDR(7'h42)) dut (
    .clock(clock), .reset(reset), .scl_rise(scl_rise), .scl_fall(scl_fall),
    .i2c_start(i2c_start), .i2c_stop(i2c_stop), .sda_in(sda_in),
    .sipo_full(sipo_full), .sipo_out(sipo_out), .piso_out(piso_out),
    .piso_empty(piso_empty), .tx_ready(tx_ready), .sipo_load(sipo_load),
    .sipo_clear(sipo_clear), .store(store), .piso_load(piso_load),
    .piso_spit(piso_spit), .sda_drive_low(sda_drive_low), .writeOK(writeOK),
    .rd_req(rd_req), .rw_bit(rw_bit), .busy(busy)
  );

  // SIPO, RX register and PISO models
  always @(posedge clock or posedge reset) begin
    if (reset) begin
      sreg <= 8'h00; scnt <= 4'd0; preg <= 8'h00; pcnt <= 4'd0; rx_reg <= 8'h00;
    end else begin
      if (sipo_clear) begin
        sreg <= 8'h00; scnt <= 4'd0;
      end else if (sipo_load) begin
        sreg <= {sreg[6:0], sda_in};
        if (scnt != 4'd8) scnt <= scnt + 4'd1;
      end
      if (store) rx_reg <= sreg;
      if (piso_load) begin
        preg <= tx_data; pcnt <= 4'd8;
      end else if (piso_spit) begin
        preg <= {preg[6:0], 1'b0};
        if (pcnt != 4'd0) pcnt <= pcnt - 4'd1;
      end
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // output monitor / scoreboard consumer
  initial begin
    logic sda_prev, ss_prev, store_prev;
    sda_prev = 1'b0; ss_prev = 1'b0; store_prev = 1'b0;
    forever begin
      @(negedge clock);
      if (store) n_store++;
      if (rd_req) n_rdreq++;
      if (sda_drive_low) n_sda_hi++;
      if (writeOK) begin
        n_wok++;
        if (wq.size() == 0) chk("wok_unexpected", 32'd1, 32'd0);
        else chk("wok_data", {24'd0, rx_reg}, {24'd0, wq.pop_front()});
      end
      if (writeOK || store_prev) chk("wok_timing", {31'd0, writeOK}, {31'd0, store_prev});
      if (piso_load || rd_req) chk("load_req", {31'd0, piso_load}, {31'd0, rd_req});
      if ((sda_drive_low != sda_prev) && !ss_prev && !reset)
        chk("sda_scl_high", {31'd0, scl_lvl}, 32'd0);
      sda_prev   = sda_drive_low;
      ss_prev    = i2c_start | i2c_stop;
      store_prev = store;
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic clk_bit(input logic b, output logic line);
    sda_m = b;
    tick(2);
    scl_rise = 1'b1; scl_lvl = 1'b1; line = sda_in;
    tick(1);
    scl_rise = 1'b0;
    tick(3);
    scl_fall = 1'b1; scl_lvl = 1'b0;
    tick(1);
    scl_fall = 1'b0;
    tick(3);
  endtask

  task automatic send_bits(input logic [7:0] b, input int n);
    logic dummy;
    for (int i = 0; i < n; i++) clk_bit(b[7-i], dummy);
  endtask

  task automatic send_byte(input logic [7:0] b, output logic ack);
    send_bits(b, 8);
    clk_bit(1'b1, ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    logic bv, dummy;
    for (int i = 0; i < 8; i++) begin
      clk_bit(1'b1, bv);
      d[7-i] = bv;
    end
    clk_bit(mack, dummy);
  endtask

  task automatic bus_start();
    if (!scl_lvl) begin
      sda_m = 1'b1;
      tick(2);
      scl_rise = 1'b1; scl_lvl = 1'b1;
      tick(1);
      scl_rise = 1'b0;
    end
    tick(2);
    i2c_start = 1'b1; sda_m = 1'b0;
    tick(1);
    i2c_start = 1'b0;
    tick(2);
    scl_fall = 1'b1; scl_lvl = 1'b0;
    tick(1);
    scl_fall = 1'b0;
    tick(3);
  endtask

  task automatic bus_stop();
    sda_m = 1'b0;
    tick(2);
    scl_rise = 1'b1; scl_lvl = 1'b1;
    tick(1);
    scl_rise = 1'b0;
    tick(2);
    i2c_stop = 1'b1; sda_m = 1'b1;
    tick(1);
    i2c_stop = 1'b0;
    tick(3);
  endtask

  initial begin
    logic       ack;
    logic [7:0] d;
    int         snap_hi, snap_st, snap_rq;
    reset = 1'b1;
    scl_rise = 0; scl_fall = 0; i2c_start = 0; i2c_stop = 0;
    sda_m = 1'b1; scl_lvl = 1'b1; tx_ready = 1'b0; tx_data = 8'h00;
    tick(3);
    chk("reset_outs", {22'd0, sipo_load, sipo_clear, store, piso_load, piso_spit,
                       sda_drive_low, writeOK, rd_req, rw_bit, busy}, 32'd0);
    reset = 1'b0;
    tick(3);

    // write 0xA5 to 0x42
    bus_start();
    send_byte(8'h84, ack);
    chk("wr_addr_ack", {31'd0, ack}, 32'd0);
    chk("wr_rw_bit", {31'd0, rw_bit}, 32'd0);
    chk("wr_busy", {31'd0, busy}, 32'd1);
    wq.push_back(8'hA5);
    send_byte(8'hA5, ack);
    chk("wr_data_ack", {31'd0, ack}, 32'd0);
    chk("wr_rx_reg", {24'd0, rx_reg}, 32'h0000_00A5);
    bus_stop();
    chk("wr_busy_stop", {31'd0, busy}, 32'd0);
    chk("wr_wok_cnt", n_wok, 1);

    // address mismatch: NACK, ignored until STOP
    snap_hi = n_sda_hi;
    bus_start();
    send_byte(8'h46, ack);
    chk("mis_nack", {31'd0, ack}, 32'd1);
    chk("mis_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h84, ack);
    chk("mis_wait_stop", {31'd0, ack}, 32'd1);
    bus_stop();
    chk("mis_sda_never", n_sda_hi - snap_hi, 0);

    // single-byte read, master NACK
    tx_ready = 1'b1; tx_data = 8'h3C;
    snap_rq = n_rdreq;
    bus_start();
    send_byte(8'h85, ack);
    chk("rd_addr_ack", {31'd0, ack}, 32'd0);
    chk("rd_rw_bit", {31'd0, rw_bit}, 32'd1);
    read_byte(1'b1, d);
    chk("rd_byte", {24'd0, d}, 32'h0000_003C);
    chk("rd_req_cnt", n_rdreq - snap_rq, 1);
    chk("rd_wait_stop", {31'd0, busy}, 32'd0);
    bus_stop();

    // multi-byte read, second byte underruns
    tx_ready = 1'b1; tx_data = 8'h96;
    snap_rq = n_rdreq;
    bus_start();
    send_byte(8'h85, ack);
    chk("mrd_addr_ack", {31'd0, ack}, 32'd0);
    tx_ready = 1'b0; tx_data = 8'h00;
    read_byte(1'b0, d);
    chk("mrd_byte1", {24'd0, d}, 32'h0000_0096);
    chk("mrd_req_cnt", n_rdreq - snap_rq, 2);
    read_byte(1'b1, d);
    chk("mrd_underrun", {24'd0, d}, 32'h0000_00FF);
    bus_stop();

    // repeated START in the middle of a write byte
    snap_st = n_store;
    bus_start();
    send_byte(8'h84, ack);
    chk("rs_addr_ack", {31'd0, ack}, 32'd0);
    send_bits(8'hA5, 4);
    tx_ready = 1'b1; tx_data = 8'h5A;
    bus_start();
    send_byte(8'h85, ack);
    chk("rs_read_ack", {31'd0, ack}, 32'd0);
    chk("rs_rw_bit", {31'd0, rw_bit}, 32'd1);
    read_byte(1'b1, d);
    chk("rs_rd_byte", {24'd0, d}, 32'h0000_005A);
    chk("rs_no_store", n_store - snap_st, 0);
    bus_stop();

    // reset while ACK is being driven
    bus_start();
    send_bits(8'h84, 8);
    chk("rst_ack_driven", {31'd0, sda_drive_low}, 32'd1);
    reset = 1'b1;
    #1;
    chk("rst_async_sda", {31'd0, sda_drive_low}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    tick(2);
    reset = 1'b0;
    sda_m = 1'b1;
    tick(2);
    bus_stop();

    // general call
    bus_start();
    send_byte(8'h00, ack);
`ifdef I2C_GENERAL_CALL_EN
    chk("gc_ack", {31'd0, ack}, 32'd0);
`else
    chk("gc_ack", {31'd0, ack}, 32'd1);
`endif
    chk("gc_rw_bit", {31'd0, rw_bit}, 32'd0);
    bus_stop();
    bus_start();
    send_byte(8'h01, ack);
    chk("gc_read_nack", {31'd0, ack}, 32'd1);
    bus_stop();

    tick(4);
    chk("wq_drained", wq.size(), 0);
    chk("tot_wok", n_wok, 1);
    chk("tot_store", n_store, 1);
    chk("tot_rd_req", n_rdreq, 4);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
